// File: rtl/igr_wadj_fc_ctrl.sv
// Ingress flow-control/drop stage between MAC RX and the width-adjust buffer.
// Drops whole packets above the drop level, raises rx_pause with hysteresis, keeps saturating stats.
module igr_wadj_fc_ctrl #(
  parameter int DATA_W     = 64,
  parameter int FILL_W     = 16,
  parameter int PAUSE_HYST = 64,
  parameter int PAUSE_MIN  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_rx_pause_en,
  input  logic [15:0]       cfg_rx_pause_threshold,
  input  logic [15:0]       cfg_drop_threshold,
  input  logic [FILL_W-1:0] fifo_fill,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic              rx_pause,
  input  logic              stat_clr,
  output logic [31:0]       drop_pkt_cnt,
  output logic [31:0]       pause_evt_cnt,
  output logic [31:0]       orphan_beat_cnt
);

  localparam int TMR_W = (PAUSE_MIN > 2) ? $clog2(PAUSE_MIN) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XOFF      = 2'd1,
    XOFF_HOLD = 2'd2
  } pause_state_e;

  pause_state_e state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             rx_pause_q;

  logic in_pkt_q, in_pkt_d;
  logic drop_cur_q, drop_cur_d;
  logic out_valid_q, out_sop_q, out_eop_q;
  logic [DATA_W-1:0] out_data_q;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] pause_cnt_q, pause_cnt_d;
  logic [31:0] orphan_cnt_q, orphan_cnt_d;

  logic [15:0] fill_ext;
  logic [15:0] hyst_ext;
  logic [15:0] low_mark;
  logic        drop_now;
  logic        keep;
  logic        orphan;
  logic        drop_sop;
  logic        pause_evt;

  assign fill_ext = 16'(fifo_fill);
  assign hyst_ext = 16'(PAUSE_HYST);
  assign low_mark = (cfg_rx_pause_threshold > hyst_ext) ? (cfg_rx_pause_threshold - hyst_ext) : 16'd0;
  assign drop_now = (fill_ext >= cfg_drop_threshold);

  function automatic logic [31:0] satNext(input logic [31:0] cnt, input logic inc, input logic clr);
    if (clr)
      return 32'd0;
    else if (inc && (cnt != 32'hFFFF_FFFF))
      return cnt + 32'd1;
    else
      return cnt;
  endfunction

  // The drop decision is latched on SOP so a packet in flight never changes fate.
  always_comb begin
    keep       = 1'b0;
    orphan     = 1'b0;
    drop_sop   = 1'b0;
    in_pkt_d   = in_pkt_q;
    drop_cur_d = drop_cur_q;
    if (in_valid) begin
      if (in_sop) begin
        drop_cur_d = drop_now;
        in_pkt_d   = !in_eop;
        keep       = !drop_now;
        drop_sop   = drop_now;
      end else if (in_pkt_q) begin
        keep = !drop_cur_q;
        if (in_eop)
          in_pkt_d = 1'b0;
      end else begin
        orphan = 1'b1;
      end
    end
  end

  // XOFF spends PAUSE_MIN-1 cycles counting down, so with one HOLD cycle pause lasts at least PAUSE_MIN.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pause_evt = 1'b0;
    if (!cfg_rx_pause_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_ext >= cfg_rx_pause_threshold) begin
            state_d   = XOFF;
            timer_d   = TMR_W'(PAUSE_MIN - 1);
            pause_evt = 1'b1;
          end
        end
        XOFF: begin
          if (timer_q != '0)
            timer_d = timer_q - TMR_W'(1);
          if (timer_q <= TMR_W'(1))
            state_d = XOFF_HOLD;
        end
        XOFF_HOLD: begin
          if (fill_ext < low_mark)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drop_cnt_d   = satNext(drop_cnt_q, drop_sop, stat_clr);
    pause_cnt_d  = satNext(pause_cnt_q, pause_evt, stat_clr);
    orphan_cnt_d = satNext(orphan_cnt_q, orphan, stat_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      rx_pause_q   <= 1'b0;
      in_pkt_q     <= 1'b0;
      drop_cur_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      drop_cnt_q   <= '0;
      pause_cnt_q  <= '0;
      orphan_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rx_pause_q   <= (state_d != IDLE);
      in_pkt_q     <= in_pkt_d;
      drop_cur_q   <= drop_cur_d;
      out_valid_q  <= keep;
      out_sop_q    <= keep & in_sop;
      out_eop_q    <= keep & in_eop;
      drop_cnt_q   <= drop_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      orphan_cnt_q <= orphan_cnt_d;
    end
  end

  // Data carries no reset; it is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (in_valid)
      out_data_q <= in_data;
  end

  assign out_valid       = out_valid_q;
  assign out_sop         = out_sop_q;
  assign out_eop         = out_eop_q;
  assign out_data        = out_data_q;
  assign rx_pause        = rx_pause_q;
  assign drop_pkt_cnt    = drop_cnt_q;
  assign pause_evt_cnt   = pause_cnt_q;
  assign orphan_beat_cnt = orphan_cnt_q;

endmodule
